// File: rtl/store_commit_queue_pkg.sv
// ---------------------------------------------------------------------------
// store_commit_queue_pkg
//   Shared types and constants for the store commit queue.
//   - SQ_ROB_W is derived from ROB_LENGTH so the tag width follows the ROB.
//   - sq_entry_t is the layout of one queue slot: {rob_addr, addr, data}.
//   The entry layout is fixed by these constants; the queue parameters
//   default to them and are expected to agree.
// ---------------------------------------------------------------------------
package store_commit_queue_pkg;

    localparam int ROB_LENGTH = 16;
    localparam int SQ_ROB_W   = $clog2(ROB_LENGTH);
    localparam int SQ_ADDR_W  = 8;
    localparam int SQ_DATA_W  = 8;
    localparam int SQ_DEPTH   = 8;

    typedef struct packed {
        logic [SQ_ROB_W-1:0]  rob_addr;
        logic [SQ_ADDR_W-1:0] addr;
        logic [SQ_DATA_W-1:0] data;
    } sq_entry_t;

endpackage

// File: rtl/store_commit_queue_fwd.sv
// ---------------------------------------------------------------------------
// store_fwd_search
//   Combinational youngest-match search over the live entries [head, tail)
//   of the circular store queue.
//   Ports:
//     entries_i   - full entry array, indexed by pointer mod DEPTH
//     head_i      - oldest live pointer (PTR_W bits, MSB is the wrap bit)
//     tail_i      - one past the youngest live pointer
//     fwd_addr_i  - load lookup address
//     hit_o       - some live entry matches fwd_addr_i
//     data_o      - data of the youngest matching entry (0 when no hit)
// ---------------------------------------------------------------------------
module store_fwd_search
    import store_commit_queue_pkg::*;
#(
    parameter int DEPTH  = SQ_DEPTH,
    parameter int ADDR_W = SQ_ADDR_W,
    parameter int DATA_W = SQ_DATA_W,
    parameter int PTR_W  = $clog2(SQ_DEPTH) + 1
) (
    input  sq_entry_t         entries_i [DEPTH],
    input  logic [PTR_W-1:0]  head_i,
    input  logic [PTR_W-1:0]  tail_i,
    input  logic [ADDR_W-1:0] fwd_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] off;
    logic [IDX_W-1:0] idx;

    // Walk from oldest (offset 0 from head) to youngest; a later match
    // overrides an earlier one, so the survivor is the one closest to tail.
    // Walking by age offset rather than by raw index keeps wrap-around correct.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        count  = tail_i - head_i;
        off    = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            off = PTR_W'(k);
            idx = head_i[IDX_W-1:0] + off[IDX_W-1:0];
            if ((off < count) && (entries_i[idx].addr == fwd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_commit_queue.sv
// ---------------------------------------------------------------------------
// store_commit_queue
//   Holds issued stores speculatively until the ROB retires their tag, then
//   drains committed stores in order to data memory; forwards store data to
//   loads; a flush discards all uncommitted entries.
//
//   Three pointers (head, cmt, tail), each clog2(DEPTH)+1 bits:
//     committed region   [head, cmt)  - drained to memory
//     speculative region [cmt, tail)  - waiting for retire
//
//   Ports:
//     clk, n_rst                        clock, synchronous active-low reset
//     in_valid/in_rob_addr/in_addr/in_data  issued store
//     pop                               store accepted this cycle
//     full, empty                       occupancy flags (registered pointers)
//     commit_valid/commit_rob_addr      ROB retire of a store tag
//     commit_err                        sticky: retire did not match oldest
//     flush                             drop speculative entries
//     mem_req/mem_addr/mem_data/mem_ack head store to memory, req/ack
//     fwd_addr/fwd_hit/fwd_data         load forwarding lookup
//
//   Handshakes: a transfer happens on a rising clk edge where the producer's
//   valid (in_valid / mem_req) and the consumer's ready (pop / mem_ack) are
//   both high; mem_addr/mem_data hold steady while mem_req waits for mem_ack.
// ---------------------------------------------------------------------------
module store_commit_queue
    import store_commit_queue_pkg::*;
#(
    parameter int DEPTH  = SQ_DEPTH,
    parameter int ADDR_W = SQ_ADDR_W,
    parameter int DATA_W = SQ_DATA_W,
    parameter int ROB_W  = SQ_ROB_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    input  logic [ROB_W-1:0]  in_rob_addr,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              pop,
    output logic              full,
    output logic              empty,
    input  logic              commit_valid,
    input  logic [ROB_W-1:0]  commit_rob_addr,
    output logic              commit_err,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    sq_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] cmt_q,  cmt_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             err_q,  err_d;

    logic commit_ok;
    logic drain;

    assign full  = ((tail_q - head_q) == DEPTH_P);
    assign empty = (tail_q == head_q);

    // Flush blocks enqueue so a store issued on the flush cycle is never
    // written behind the rewound tail.
    assign pop = in_valid & ~full & ~flush;

    assign commit_ok = commit_valid & (cmt_q != tail_q) &
                       (entries_q[cmt_q[IDX_W-1:0]].rob_addr == commit_rob_addr);

    assign mem_req  = (head_q != cmt_q);
    assign mem_addr = entries_q[head_q[IDX_W-1:0]].addr;
    assign mem_data = entries_q[head_q[IDX_W-1:0]].data;
    assign drain    = mem_req & mem_ack;

    assign commit_err = err_q;

    always_comb begin
        head_d = head_q + PTR_W'(drain);
        cmt_d  = cmt_q + PTR_W'(commit_ok);
        err_d  = err_q | (commit_valid & ~commit_ok);
        // Rewind to the post-commit cmt so a same-cycle retire survives flush.
        if (flush) begin
            tail_d = cmt_d;
        end else begin
            tail_d = tail_q + PTR_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

    // Entry storage needs no reset: only slots inside [head, tail) are read
    // meaningfully, and pop is only asserted with n_rst high in practice.
    always_ff @(posedge clk) begin
        if (pop) begin
            entries_q[tail_q[IDX_W-1:0]] <= '{rob_addr: in_rob_addr,
                                              addr:     in_addr,
                                              data:     in_data};
        end
    end

    store_fwd_search #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_fwd (
        .entries_i  (entries_q),
        .head_i     (head_q),
        .tail_i     (tail_q),
        .fwd_addr_i (fwd_addr),
        .hit_o      (fwd_hit),
        .data_o     (fwd_data)
    );

endmodule
